fetch_cancel_tracker: RTL and testbench
=======================================

Name: fetch_cancel_tracker

Overview:
Tracks in-flight instruction-fetch requests between pre-IF and IF and decides which returning fetch responses belong to a squashed (wrong) path. This generalises the single-bit cancel flag to up to MAX_OUTSTANDING outstanding requests and NUM_FLUSH independent redirect sources (e.g. ID branch, EX/WB exception/ertn). Sits beside the IF stage; IF consumes resp_discard to drop stale instructions, and pre-IF consumes req_block for back-pressure.

Parameters:
MAX_OUTSTANDING, 4, maximum accepted-but-unanswered fetch requests (1..15)
CNT_W, 3, counter width; must satisfy 2^CNT_W > MAX_OUTSTANDING
NUM_FLUSH, 2, number of redirect sources; bit index = priority (highest index wins)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low (rst==0 resets)
req_fire  in  1  fetch request accepted by memory this cycle (req & addr_ok)
resp_fire  in  1  fetch response returned this cycle (data_ok)
flush  in  NUM_FLUSH  redirect requests this cycle, one bit per source
outstanding_cnt  out  CNT_W  accepted requests not yet answered
cancel_cnt  out  CNT_W  outstanding responses still to be discarded
resp_discard  out  1  current resp_fire is wrong-path; IF must drop it
req_block  out  1  outstanding_cnt==MAX_OUTSTANDING; pre-IF must not fire
draining  out  1  state==DRAIN
last_flush_src  out  NUM_FLUSH  one-hot source of most recent flush (priority-resolved)
err  out  1  protocol error flag (see Optional Feature)

Behaviour:
- Reset (rst low, async): outstanding_cnt=0, cancel_cnt=0, state=IDLE, last_flush_src=0, err=0. Outputs valid in the first cycle after rst rises.
- Effective events: req_eff = req_fire & (outstanding_cnt!=MAX_OUTSTANDING); resp_eff = resp_fire & (outstanding_cnt!=0). Ignored events do not change counters.
- outstanding_next = outstanding_cnt + req_eff - resp_eff (both same cycle: unchanged).
- resp_discard (combinational) = resp_eff & (cancel_cnt!=0). Independent of flush in the same cycle: a response landing in the flush cycle is judged against the pre-flush cancel_cnt.
- flush_any = |flush.
  - flush_any: cancel_next = outstanding_next. A request accepted in the flush cycle was issued on the old path and is cancelled. A response returned in the flush cycle is already consumed and is not counted.
  - else: cancel_next = cancel_cnt - resp_discard.
- Invariant: cancel_cnt <= outstanding_cnt always.
- Back-to-back flushes: each flush reloads cancel_cnt from outstanding_next; the count never accumulates beyond outstanding.
- last_flush_src: on flush_any, loads one-hot of the highest set flush index; otherwise holds.
- req_block = (outstanding_cnt==MAX_OUTSTANDING); purely registered-state based, no combinational path from inputs.
- FSM (state register, 1 bit):
  - IDLE: cancel_cnt==0. On flush_any with outstanding_next!=0 -> DRAIN; else stay.
  - DRAIN: when cancel_next==0 -> IDLE; a flush while in DRAIN stays in DRAIN if outstanding_next!=0.
  - State always equals (cancel_cnt!=0); an implementation asserting this is required.

Optional Feature:
Macro FETCH_CANCEL_ERR_CHK_EN.
- Defined: err is sticky and set on resp_fire with outstanding_cnt==0, or on req_fire with outstanding_cnt==MAX_OUTSTANDING. It is cleared only by reset. The offending event is still ignored.
- Undefined: err tied to 0; illegal events are silently ignored (saturation only).

Test Plan:
- Reset mid-operation: outstanding=3, cancel=2, pull rst low asynchronously between edges -> all outputs 0 immediately, state IDLE.
- 2 req_fire, then flush[0] with no req/resp that cycle -> cancel_cnt=2, draining=1. Next 2 resp_fire -> resp_discard=1 both; then cancel=0, IDLE. Third resp after a new req -> resp_discard=0.
- Flush with req_fire and resp_fire in the same cycle, outstanding=2 -> that resp_discard=0 (cancel was 0), outstanding stays 2, cancel_cnt=2.
- Fill to 4 outstanding -> req_block=1; extra req_fire ignored (outstanding stays 4; err=1 with FETCH_CANCEL_ERR_CHK_EN, 0 without).
- flush=2'b11 -> last_flush_src=2'b10. Second flush while cancel=1, outstanding=3 -> cancel_cnt reloads to 3.
- resp_fire with outstanding=0 -> counters stay 0, resp_discard=0, err per macro.

Source files
------------

// File: rtl/fetch_cancel_tracker.sv
// ---------------------------------------------------------------------------
// fetch_cancel_tracker
//
// Counts fetch requests that memory has accepted but not yet answered.
// After a redirect it marks every one of those requests as wrong-path, so
// that IF drops their responses when they return. Redirects can come from
// several sources, and a redirect that arrives while the previous one is
// still draining simply reloads the cancel count.
//
// Optional feature macro: FETCH_CANCEL_ERR_CHK_EN
//   defined   : err is a sticky flag for protocol violations (a response
//               with nothing outstanding, or a request while full)
//   undefined : err is tied to 0
//
// Ports
//   clk             clock, all state changes on the rising edge
//   rst             asynchronous reset, active low
//   req_fire        memory accepted a fetch request this cycle
//   resp_fire       a fetch response returned this cycle
//   flush           redirect requests, one bit per source; higher index wins
//   outstanding_cnt accepted requests not yet answered
//   cancel_cnt      outstanding responses still to be discarded
//   resp_discard    the current response is wrong-path and must be dropped
//   req_block       the tracker is full; pre-IF must not fire a request
//   draining        FSM is in DRAIN
//   last_flush_src  one-hot source of the most recent redirect
//   err             protocol error flag
//
// FSM states
//   state | meaning
//   IDLE  | no wrong-path responses pending (cancel_cnt == 0)
//   DRAIN | wrong-path responses still to be discarded
// ---------------------------------------------------------------------------
module fetch_cancel_tracker #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3,
    parameter int NUM_FLUSH       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_fire,
    input  logic                 resp_fire,
    input  logic [NUM_FLUSH-1:0] flush,
    output logic [CNT_W-1:0]     outstanding_cnt,
    output logic [CNT_W-1:0]     cancel_cnt,
    output logic                 resp_discard,
    output logic                 req_block,
    output logic                 draining,
    output logic [NUM_FLUSH-1:0] last_flush_src,
    output logic                 err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   req_eff;
    logic                   resp_eff;
    logic                   flush_any;
    logic [CNT_W-1:0]       outstanding_next;
    logic [CNT_W-1:0]       cancel_next;
    logic [NUM_FLUSH-1:0]   flush_onehot;

    always_comb begin
        req_eff      = req_fire && (outstanding_cnt != MAX_CNT);
        resp_eff     = resp_fire && (outstanding_cnt != '0);
        // Judged against the pre-flush count: a response landing in the
        // flush cycle belongs to a request issued before the redirect was
        // known, and only already-cancelled ones are dropped.
        resp_discard = resp_eff && (cancel_cnt != '0);
        flush_any    = |flush;

        outstanding_next = outstanding_cnt;
        if (req_eff && !resp_eff) begin
            outstanding_next = outstanding_cnt + ONE;
        end else if (!req_eff && resp_eff) begin
            outstanding_next = outstanding_cnt - ONE;
        end

        // A redirect cancels everything still in flight after this cycle,
        // including a request accepted in the same cycle on the old path.
        if (flush_any) begin
            cancel_next = outstanding_next;
        end else if (resp_discard) begin
            cancel_next = cancel_cnt - ONE;
        end else begin
            cancel_next = cancel_cnt;
        end

        flush_onehot = '0;
        for (int i = 0; i < NUM_FLUSH; i++) begin
            if (flush[i]) begin
                flush_onehot    = '0;
                flush_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (flush_any && (outstanding_next != '0)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (cancel_next == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            outstanding_cnt <= '0;
            cancel_cnt      <= '0;
            last_flush_src  <= '0;
        end else begin
            state           <= state_next;
            outstanding_cnt <= outstanding_next;
            cancel_cnt      <= cancel_next;
            if (flush_any) begin
                last_flush_src <= flush_onehot;
            end
        end
    end

`ifdef FETCH_CANCEL_ERR_CHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if ((resp_fire && (outstanding_cnt == '0)) ||
                     (req_fire && (outstanding_cnt == MAX_CNT))) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    assign req_block = (outstanding_cnt == MAX_CNT);
    assign draining  = (state == DRAIN);

    a_state_matches_cancel : assert property (
        @(posedge clk) disable iff (!rst) (state == DRAIN) == (cancel_cnt != '0));

    a_cancel_le_outstanding : assert property (
        @(posedge clk) disable iff (!rst) cancel_cnt <= outstanding_cnt);

endmodule

// File: tb/tb_fetch_cancel_tracker.sv
module tb_fetch_cancel_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_fire = 1'b0;
    logic       resp_fire = 1'b0;
    logic [1:0] flush = 2'b00;
    logic [2:0] outstanding_cnt;
    logic [2:0] cancel_cnt;
    logic       resp_discard;
    logic       req_block;
    logic       draining;
    logic [1:0] last_flush_src;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

`ifdef FETCH_CANCEL_ERR_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    fetch_cancel_tracker #(
        .MAX_OUTSTANDING(4),
        .CNT_W(3),
        .NUM_FLUSH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_fire(req_fire),
        .resp_fire(resp_fire),
        .flush(flush),
        .outstanding_cnt(outstanding_cnt),
        .cancel_cnt(cancel_cnt),
        .resp_discard(resp_discard),
        .req_block(req_block),
        .draining(draining),
        .last_flush_src(last_flush_src),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Record: inputs for one cycle, resp_discard expected during it, and
    // register outputs expected just after the following rising edge.
    typedef struct {
        bit       req;
        bit       resp;
        bit [1:0] fl;
        bit       disc;
        int       outc;
        int       canc;
        bit       drn;
        bit       blk;
        bit [1:0] src;
        bit       err_if_en;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(bit req, bit resp, bit [1:0] fl, bit disc, int outc,
                                int canc, bit drn, bit blk, bit [1:0] src, bit e);
        vec_t v;
        v.req = req; v.resp = resp; v.fl = fl; v.disc = disc; v.outc = outc;
        v.canc = canc; v.drn = drn; v.blk = blk; v.src = src; v.err_if_en = e;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        req_fire = 0; resp_fire = 0; flush = 0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One cycle: drive at negedge, check combinational discard, clock, check state.
    task automatic step(input bit r, input bit s, input bit [1:0] f,
                        input bit exp_disc, input int exp_out, input int exp_can);
        @(negedge clk);
        req_fire = r; resp_fire = s; flush = f;
        #1;
        chk("resp_discard", int'(resp_discard), int'(exp_disc));
        @(posedge clk);
        #1;
        chk("outstanding_cnt", int'(outstanding_cnt), exp_out);
        chk("cancel_cnt", int'(cancel_cnt), exp_can);
    endtask

    // Reference model: a queue of in-flight requests, each flagged when a
    // redirect has made it wrong-path.
    bit m_q[$];
    bit [1:0] m_src;
    bit m_err;

    function automatic int m_cancel();
        int c = 0;
        foreach (m_q[i]) if (m_q[i]) c++;
        return c;
    endfunction

    initial begin
        vecs[0]  = mk(1, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 0);
        vecs[1]  = mk(1, 0, 2'b00, 0, 2, 0, 0, 0, 2'b00, 0);
        vecs[2]  = mk(0, 0, 2'b01, 0, 2, 2, 1, 0, 2'b01, 0);
        vecs[3]  = mk(0, 1, 2'b00, 1, 1, 1, 1, 0, 2'b01, 0);
        vecs[4]  = mk(0, 1, 2'b00, 1, 0, 0, 0, 0, 2'b01, 0);
        vecs[5]  = mk(1, 0, 2'b00, 0, 1, 0, 0, 0, 2'b01, 0);
        vecs[6]  = mk(0, 1, 2'b00, 0, 0, 0, 0, 0, 2'b01, 0);
        vecs[7]  = mk(1, 0, 2'b00, 0, 1, 0, 0, 0, 2'b01, 0);
        vecs[8]  = mk(1, 0, 2'b00, 0, 2, 0, 0, 0, 2'b01, 0);
        vecs[9]  = mk(1, 1, 2'b01, 0, 2, 2, 1, 0, 2'b01, 0);
        vecs[10] = mk(0, 1, 2'b00, 1, 1, 1, 1, 0, 2'b01, 0);
        vecs[11] = mk(0, 1, 2'b00, 1, 0, 0, 0, 0, 2'b01, 0);
        vecs[12] = mk(1, 0, 2'b00, 0, 1, 0, 0, 0, 2'b01, 0);
        vecs[13] = mk(1, 0, 2'b00, 0, 2, 0, 0, 0, 2'b01, 0);
        vecs[14] = mk(1, 0, 2'b00, 0, 3, 0, 0, 0, 2'b01, 0);
        vecs[15] = mk(1, 0, 2'b00, 0, 4, 0, 0, 1, 2'b01, 0);
        vecs[16] = mk(1, 0, 2'b00, 0, 4, 0, 0, 1, 2'b01, 1);
        vecs[17] = mk(0, 1, 2'b00, 0, 3, 0, 0, 0, 2'b01, 1);
        vecs[18] = mk(0, 1, 2'b00, 0, 2, 0, 0, 0, 2'b01, 1);
        vecs[19] = mk(0, 1, 2'b00, 0, 1, 0, 0, 0, 2'b01, 1);
        vecs[20] = mk(0, 1, 2'b00, 0, 0, 0, 0, 0, 2'b01, 1);
        vecs[21] = mk(0, 1, 2'b00, 0, 0, 0, 0, 0, 2'b01, 1);

        do_reset();
        #1;
        chk("reset outstanding", int'(outstanding_cnt), 0);
        chk("reset cancel", int'(cancel_cnt), 0);
        chk("reset draining", int'(draining), 0);
        chk("reset src", int'(last_flush_src), 0);
        chk("reset err", int'(err), 0);
        chk("reset block", int'(req_block), 0);

        // Table-driven vectors
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            req_fire = vecs[i].req; resp_fire = vecs[i].resp; flush = vecs[i].fl;
            #1;
            chk($sformatf("vec%0d resp_discard", i), int'(resp_discard), int'(vecs[i].disc));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d outstanding", i), int'(outstanding_cnt), vecs[i].outc);
            chk($sformatf("vec%0d cancel", i), int'(cancel_cnt), vecs[i].canc);
            chk($sformatf("vec%0d draining", i), int'(draining), int'(vecs[i].drn));
            chk($sformatf("vec%0d req_block", i), int'(req_block), int'(vecs[i].blk));
            chk($sformatf("vec%0d src", i), int'(last_flush_src), int'(vecs[i].src));
            chk($sformatf("vec%0d err", i), int'(err), int'(vecs[i].err_if_en & ERR_EN));
        end

        // Re-flush while draining reloads the count; both sources -> higher wins
        do_reset();
        step(1, 0, 2'b00, 0, 1, 0);
        step(1, 0, 2'b00, 0, 2, 0);
        step(0, 0, 2'b01, 0, 2, 2);
        step(1, 0, 2'b00, 0, 3, 2);
        step(0, 1, 2'b00, 1, 2, 1);
        step(1, 0, 2'b00, 0, 3, 1);
        step(0, 0, 2'b11, 0, 3, 3);
        chk("dual flush src", int'(last_flush_src), 2);
        chk("reflush draining", int'(draining), 1);

        // Asynchronous reset in the middle of a drain: outstanding=3, cancel=2
        do_reset();
        step(1, 0, 2'b00, 0, 1, 0);
        step(1, 0, 2'b00, 0, 2, 0);
        step(0, 0, 2'b01, 0, 2, 2);
        step(1, 0, 2'b00, 0, 3, 2);
        @(negedge clk);
        req_fire = 0; resp_fire = 0; flush = 0;
        #2;
        rst = 1'b0;
        #1;
        chk("async rst outstanding", int'(outstanding_cnt), 0);
        chk("async rst cancel", int'(cancel_cnt), 0);
        chk("async rst draining", int'(draining), 0);
        chk("async rst src", int'(last_flush_src), 0);
        chk("async rst discard", int'(resp_discard), 0);
        @(negedge clk);
        rst = 1'b1;

        // Randomized run against the queue model
        do_reset();
        m_q.delete();
        m_src = 0;
        m_err = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit r, s, d;
            bit [1:0] f;
            bit r_ok, s_ok;
            @(negedge clk);
            r = ($urandom_range(99) < 55);
            s = ($urandom_range(99) < 50);
            f = ($urandom_range(99) < 12) ? 2'($urandom_range(3)) : 2'b00;
            req_fire = r; resp_fire = s; flush = f;
            r_ok = r && (m_q.size() < 4);
            s_ok = s && (m_q.size() > 0);
            d = s_ok && m_q[0];
            #1;
            chk("rnd resp_discard", int'(resp_discard), int'(d));
            chk("rnd outstanding", int'(outstanding_cnt), m_q.size());
            chk("rnd cancel", int'(cancel_cnt), m_cancel());
            chk("rnd draining", int'(draining), int'(m_cancel() != 0));
            chk("rnd req_block", int'(req_block), int'(m_q.size() == 4));
            chk("rnd src", int'(last_flush_src), int'(m_src));
            chk("rnd err", int'(err), int'(m_err));
            @(posedge clk);
            if (ERR_EN && ((s && m_q.size() == 0) || (r && m_q.size() == 4))) m_err = 1'b1;
            if (s_ok) void'(m_q.pop_front());
            if (r_ok) m_q.push_back(1'b0);
            if (f != 2'b00) begin
                foreach (m_q[i]) m_q[i] = 1'b1;
                m_src = f[1] ? 2'b10 : 2'b01;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
